// File: rtl/multiword_add_pkg.sv
// Shared types and constants for the multi-word sequential adder.
// Build option: define ADDSUB_EN to add the sub port (A-B support).
package multiword_add_pkg;

  localparam int N_DEF      = 16;
  localparam int CHUNKS_DEF = 4;
  localparam int W          = N_DEF * CHUNKS_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Chunk-index width; a single-chunk build still needs one index bit.
  function automatic int idx_width(input int chunks);
    return (chunks <= 1) ? 1 : $clog2(chunks);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational N-bit adder slice with carry-in and carry-out.
module adder_chunk #(
  parameter int N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};

endmodule

// File: rtl/multiword_add_seq.sv
// Adds two N*CHUNKS-bit operands one N-bit chunk per cycle, LSB chunk first.
// Build option: ADDSUB_EN adds the sub port (sub=1 computes A-B).
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int CHUNKS = CHUNKS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N*CHUNKS-1:0] op_a,
  input  logic [N*CHUNKS-1:0] op_b,
`ifdef ADDSUB_EN
  input  logic                sub,
`endif
  output logic                busy,
  output logic                done,
  output logic [N*CHUNKS-1:0] sum,
  output logic                carry_out,
  output logic                overflow
);

  localparam int WO = N * CHUNKS;
  localparam int IW = idx_width(CHUNKS);
  localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

  state_e         state_q, state_d;
  logic [WO-1:0]  a_q, a_d;
  logic [WO-1:0]  b_q, b_d;   // holds B already inverted when subtracting
  logic [WO-1:0]  sum_q, sum_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic           sub_eff;
  logic [N-1:0]   chunk_sum;
  logic           chunk_cout;

`ifdef ADDSUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  adder_chunk #(.N(N)) u_adder_chunk (
    .a_i   (a_q[idx_q*N +: N]),
    .b_i   (b_q[idx_q*N +: N]),
    .cin_i (carry_q),
    .sum_o (chunk_sum),
    .cout_o(chunk_cout)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = op_a;
          b_d     = sub_eff ? ~op_b : op_b;
          carry_d = sub_eff;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        sum_d[idx_q*N +: N] = chunk_sum;
        carry_d             = chunk_cout;
        idx_d               = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
          cout_d  = chunk_cout;
          // Same-sign operands producing an opposite-sign result is overflow.
          ovf_d   = (a_q[WO-1] == b_q[WO-1]) && (chunk_sum[N-1] != a_q[WO-1]);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed scoreboard bench for multiword_add_seq (N=16, CHUNKS=4).
// Sub-mode steps are included when ADDSUB_EN is defined.
module tb_multiword_add_seq;
  import multiword_add_pkg::*;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } result_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int      n_cmp = 0;
  int      n_err = 0;
  result_t sb[$];

  multiword_add_seq #(.N(16), .CHUNKS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
`ifdef ADDSUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry_out(carry_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic, independent of chunking.
  function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W:0]   full;
    logic [W-1:0] bp;
    result_t      r;
    bp     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, s};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, W'(busy), W'(0));
    check({tag, "_done"}, W'(done), W'(0));
    check({tag, "_sum"}, sum, '0);
    check({tag, "_cout"}, W'(carry_out), W'(0));
    check({tag, "_ovf"}, W'(overflow), W'(0));
  endtask

  // Waits (bounded) for done, checking busy throughout, then pops and compares.
  task automatic wait_and_compare(input string tag, input int exp_lat, input int lat0);
    int      lat;
    result_t exp_r;
    lat = lat0;
    while (done !== 1'b1 && lat < 20) begin
      check({tag, "_busy_run"}, W'(busy), W'(1));
      @(negedge clk);
      lat++;
    end
    check({tag, "_done_seen"}, W'(done), W'(1));
    check({tag, "_latency"}, W'(lat), W'(exp_lat));
    check({tag, "_busy_done"}, W'(busy), W'(1));
    check({tag, "_sb_nonempty"}, W'(sb.size() > 0), W'(1));
    if (done === 1'b1 && sb.size() > 0) begin
      exp_r = sb.pop_front();
      check({tag, "_sum"}, sum, exp_r.sum);
      check({tag, "_cout"}, W'(carry_out), W'(exp_r.cout));
      check({tag, "_ovf"}, W'(overflow), W'(exp_r.ovf));
      @(negedge clk);
      check({tag, "_done_pulse"}, W'(done), W'(0));
      check({tag, "_busy_end"}, W'(busy), W'(0));
      check({tag, "_sum_hold"}, sum, exp_r.sum);
    end
  endtask

  // Called at a falling edge; drives start for exactly one rising edge.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s);
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    sb.push_back(model(a, b, s));
    @(negedge clk);
    start = 1'b0;
    wait_and_compare(tag, 5, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    sub   = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("in_reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_idle("post_reset");

    do_op("ffff_plus_1", {W{1'b1}}, W'(1), 1'b0);
    do_op("max_pos_plus_1", {1'b0, {(W-1){1'b1}}}, W'(1), 1'b0);
    do_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);

    // Start raised again during RUN must be ignored.
    op_a  = W'(3);
    op_b  = W'(4);
    start = 1'b1;
    sb.push_back(model(W'(3), W'(4), 1'b0));
    @(negedge clk);
    start = 1'b0;
    op_a  = W'(64'hFFFF);
    op_b  = W'(64'hFFFF);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_and_compare("ignored_start", 5, 3);
    repeat (8) begin
      check("no_extra_done", W'(done), W'(0));
      @(negedge clk);
    end
    check("sb_drained", W'(sb.size()), W'(0));

    // Reset mid-operation aborts with no done pulse.
    op_a  = 64'h1_0001;
    op_b  = 64'h1_0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (7) begin
      check("abort_no_done", W'(done), W'(0));
      @(negedge clk);
    end
    do_op("restart", 64'h1_0001, 64'h1_0001, 1'b0);

`ifdef ADDSUB_EN
    do_op("sub_5_7", W'(5), W'(7), 1'b1);
    do_op("sub_min_1", {1'b1, {(W-1){1'b0}}}, W'(1), 1'b1);
    do_op("sub_eq", 64'hDEAD_BEEF_0000_1111, 64'hDEAD_BEEF_0000_1111, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
